// File: rtl/conv_pkg.sv
// Shared types, default widths and saturation-bound helpers for the CONV datapath.
package conv_pkg;

  localparam int unsigned ACC_W = 24;
  localparam int unsigned FM_W  = 16;

  typedef enum logic {IDLE, DRAIN} drain_state_t;

  function automatic longint sat_max(input int unsigned width);
    return (longint'(1) << (width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned width);
    return -(longint'(1) << (width - 1));
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: round-half-up arithmetic right shift, optional ReLU,
// saturation to the output width.
module requant_sat
  import conv_pkg::*;
#(
  parameter int unsigned BITWIDTH_IN  = ACC_W,
  parameter int unsigned BITWIDTH_OUT = FM_W,
  parameter int unsigned SHIFT_W      = 5
) (
  input  logic signed [BITWIDTH_IN-1:0]  x,
  input  logic        [SHIFT_W-1:0]      s,
  input  logic                           relu_en,
  output logic signed [BITWIDTH_OUT-1:0] sat_c
);

  // One guard bit so the rounding add cannot wrap.
  localparam int unsigned EW    = BITWIDTH_IN + 1;
  localparam int unsigned S_MAX = BITWIDTH_IN - 1;
  localparam logic signed [EW-1:0] HI = EW'(sat_max(BITWIDTH_OUT));
  localparam logic signed [EW-1:0] LO = EW'(sat_min(BITWIDTH_OUT));

  int unsigned             sc;
  logic signed [EW-1:0]    rnd;
  logic signed [EW-1:0]    sum;
  logic signed [EW-1:0]    t;

  always_comb begin
    sc    = (32'(s) > S_MAX) ? S_MAX : 32'(s);
    rnd   = (sc == 0) ? '0 : (EW'(1) << (sc - 1));
    sum   = $signed({x[BITWIDTH_IN-1], x}) + rnd;
    t     = sum >>> sc;
    if (relu_en && t[EW-1]) begin
      t = '0;
    end
    if (t > HI) begin
      sat_c = BITWIDTH_OUT'(HI);
    end else if (t < LO) begin
      sat_c = BITWIDTH_OUT'(LO);
    end else begin
      sat_c = BITWIDTH_OUT'(t);
    end
  end

endmodule

// File: rtl/psum_drain_requant.sv
// Captures a finished accumulator vector in one cycle, then streams requantized
// elements out one per valid/ready beat.
module psum_drain_requant
  import conv_pkg::*;
#(
  parameter int unsigned BITWIDTH_IN  = ACC_W,
  parameter int unsigned BITWIDTH_OUT = FM_W,
  parameter int unsigned LENGTH       = 4,
  parameter int unsigned SHIFT_W      = 5
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           acc_valid,
  input  logic signed [BITWIDTH_IN-1:0]  acc_data [LENGTH],
  input  logic        [SHIFT_W-1:0]      shift,
  input  logic                           relu_en,
  output logic                           acc_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [BITWIDTH_OUT-1:0] out_data,
  output logic [$clog2(LENGTH)-1:0]      out_idx,
  output logic                           out_last,
  output logic                           drop_err
);

  localparam int unsigned IDX_W = $clog2(LENGTH);

  drain_state_t                   state_q, state_d;
  logic signed [BITWIDTH_IN-1:0]  buf_q [LENGTH];
  logic signed [BITWIDTH_IN-1:0]  buf_d [LENGTH];
  logic        [SHIFT_W-1:0]      shift_q, shift_d;
  logic                           relu_q, relu_d;
  logic        [IDX_W-1:0]        idx_q, idx_d;
  logic                           out_valid_q, out_valid_d;
  logic signed [BITWIDTH_OUT-1:0] out_data_q, out_data_d;
  logic                           out_last_q, out_last_d;
  logic                           drop_err_q, drop_err_d;

  logic        [IDX_W-1:0]        next_idx;
  logic signed [BITWIDTH_IN-1:0]  rq_x;
  logic        [SHIFT_W-1:0]      rq_s;
  logic                           rq_relu;
  logic signed [BITWIDTH_OUT-1:0] rq_y;

  assign next_idx = out_last_q ? '0 : idx_q + IDX_W'(1);

  // Single requantizer: element 0 straight from the input at capture, else the next buffered one.
  always_comb begin
    rq_x    = acc_data[0];
    rq_s    = shift;
    rq_relu = relu_en;
    if (state_q == DRAIN) begin
      rq_x    = buf_q[next_idx];
      rq_s    = shift_q;
      rq_relu = relu_q;
    end
  end

  requant_sat #(
    .BITWIDTH_IN (BITWIDTH_IN),
    .BITWIDTH_OUT(BITWIDTH_OUT),
    .SHIFT_W     (SHIFT_W)
  ) u_requant_sat (
    .x      (rq_x),
    .s      (rq_s),
    .relu_en(rq_relu),
    .sat_c  (rq_y)
  );

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    drop_err_d  = drop_err_q;
    case (state_q)
      IDLE: begin
        if (acc_valid) begin
          buf_d       = acc_data;
          shift_d     = shift;
          relu_d      = relu_en;
          idx_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = rq_y;
          out_last_d  = 1'b0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (acc_valid) begin
          drop_err_d = 1'b1;
        end
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            idx_d      = next_idx;
            out_data_d = rq_y;
            out_last_d = (next_idx == IDX_W'(LENGTH - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      buf_q       <= '{default: '0};
      shift_q     <= '0;
      relu_q      <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign acc_ready = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;
  assign out_last  = out_last_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_psum_drain_requant.sv
// Bench for psum_drain_requant: vector table plus hand-written stall, drop and reset sequences,
// with a beat scoreboard checked on every handshake.
module tb_psum_drain_requant;

  localparam int unsigned BI = 24;
  localparam int unsigned BO = 16;
  localparam int unsigned L  = 4;
  localparam int unsigned SW = 5;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  acc_valid;
  logic signed [BI-1:0]  acc_data [L];
  logic [SW-1:0]         shift;
  logic                  relu_en;
  logic                  acc_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [BO-1:0]  out_data;
  logic [1:0]            out_idx;
  logic                  out_last;
  logic                  drop_err;

  always #5 clk = ~clk;

  psum_drain_requant #(
    .BITWIDTH_IN (BI),
    .BITWIDTH_OUT(BO),
    .LENGTH      (L),
    .SHIFT_W     (SW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .acc_valid(acc_valid),
    .acc_data (acc_data),
    .shift    (shift),
    .relu_en  (relu_en),
    .acc_ready(acc_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .drop_err (drop_err)
  );

  typedef struct {
    logic signed [BO-1:0] data;
    int                   idx;
    bit                   last;
  } beat_t;

  typedef struct {
    int d [4];
    int sh;
    bit r;
    int e [4];
  } vec_t;

  beat_t sb [$];
  vec_t  tbl [6];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int d [4], input int sh, input bit r, input int e [4]);
    acc_valid = 1'b1;
    shift     = SW'(sh);
    relu_en   = r;
    for (int i = 0; i < 4; i++) begin
      acc_data[i] = BI'(d[i]);
      sb.push_back('{BO'(e[i]), i, (i == 3)});
    end
    tick();
    acc_valid = 1'b0;
  endtask

  // Scoreboard check on every completed handshake.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      beat_t e;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got idx %0d data %0d, want no beat", out_idx, out_data);
      end else begin
        e = sb.pop_front();
        chk("beat_data", longint'(out_data), longint'(e.data));
        chk("beat_idx", longint'(out_idx), longint'(e.idx));
        chk("beat_last", longint'(out_last), longint'(e.last));
      end
    end
  end

  initial begin
    int bp [7];
    int ed [4];
    int dv [4];
    int cur;

    tbl[0].d = '{100, -200, 300, -400};    tbl[0].sh = 0;  tbl[0].r = 1'b0;
    tbl[0].e = '{100, -200, 300, -400};
    tbl[1].d = '{24, -24, 8, -8};          tbl[1].sh = 4;  tbl[1].r = 1'b0;
    tbl[1].e = '{2, -1, 1, 0};
    tbl[2].d = '{40000, -40000, 32767, -32768}; tbl[2].sh = 0; tbl[2].r = 1'b0;
    tbl[2].e = '{32767, -32768, 32767, -32768};
    tbl[3].d = '{-5, 5, -40000, 0};        tbl[3].sh = 0;  tbl[3].r = 1'b1;
    tbl[3].e = '{0, 5, 0, 0};
    tbl[4].d = '{8388607, -8388608, 4194304, -4194305}; tbl[4].sh = 31; tbl[4].r = 1'b0;
    tbl[4].e = '{1, -1, 1, -1};
    tbl[5].d = '{-7, 6, -1, 131072};       tbl[5].sh = 2;  tbl[5].r = 1'b1;
    tbl[5].e = '{0, 2, 0, 32767};

    rstn      = 1'b0;
    acc_valid = 1'b0;
    out_ready = 1'b1;
    shift     = '0;
    relu_en   = 1'b0;
    for (int i = 0; i < 4; i++) acc_data[i] = '0;

    #12;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_acc_ready", longint'(acc_ready), 1);
    chk("rst_drop_err", longint'(drop_err), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_idx", longint'(out_idx), 0);
    chk("rst_out_last", longint'(out_last), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Table: full-rate drains, LENGTH+1 cycles each.
    for (int v = 0; v < 6; v++) begin
      chk("tbl_acc_ready_pre", longint'(acc_ready), 1);
      capture(tbl[v].d, tbl[v].sh, tbl[v].r, tbl[v].e);
      chk("tbl_first_valid", longint'(out_valid), 1);
      chk("tbl_first_idx", longint'(out_idx), 0);
      chk("tbl_busy", longint'(acc_ready), 0);
      repeat (3) tick();
      chk("tbl_last_valid", longint'(out_valid), 1);
      chk("tbl_still_busy", longint'(acc_ready), 0);
      tick();
      chk("tbl_done_ready", longint'(acc_ready), 1);
      chk("tbl_done_valid", longint'(out_valid), 0);
      chk("tbl_sb_empty", longint'(sb.size()), 0);
    end

    // Backpressure: outputs hold during stalls, beats in order.
    bp = '{1, 0, 0, 1, 0, 1, 1};
    ed = '{11, 22, -33, 44};
    capture(ed, 0, 1'b0, ed);
    cur = 0;
    for (int i = 0; i < 7; i++) begin
      out_ready = bp[i][0];
      chk("bp_valid", longint'(out_valid), 1);
      chk("bp_idx", longint'(out_idx), longint'(cur));
      chk("bp_data", longint'(out_data), longint'(ed[cur]));
      if (bp[i] != 0) cur++;
      tick();
    end
    out_ready = 1'b1;
    chk("bp_done_valid", longint'(out_valid), 0);
    chk("bp_sb_empty", longint'(sb.size()), 0);

    // Drop: second vector arrives while element 1 is pending.
    ed = '{1, 2, 3, 4};
    capture(ed, 0, 1'b0, ed);
    tick();
    acc_valid = 1'b1;
    for (int i = 0; i < 4; i++) acc_data[i] = BI'(9);
    tick();
    acc_valid = 1'b0;
    chk("drop_err_set", longint'(drop_err), 1);
    chk("drop_idx", longint'(out_idx), 2);
    repeat (2) tick();
    chk("drop_done_valid", longint'(out_valid), 0);
    chk("drop_done_ready", longint'(acc_ready), 1);
    repeat (3) tick();
    chk("drop_no_second", longint'(out_valid), 0);
    chk("drop_err_sticky", longint'(drop_err), 1);
    chk("drop_sb_empty", longint'(sb.size()), 0);

    // Reset mid-drain, then a fresh vector from idx 0.
    ed = '{50, 60, 70, 80};
    capture(ed, 0, 1'b0, ed);
    tick();
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_drop_err", longint'(drop_err), 0);
    chk("mid_rst_acc_ready", longint'(acc_ready), 1);
    sb.delete();
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_ready", longint'(acc_ready), 1);
    dv = '{7, 8, 9, 10};
    capture(dv, 0, 1'b0, dv);
    chk("post_rst_idx", longint'(out_idx), 0);
    chk("post_rst_data", longint'(out_data), 7);
    repeat (4) tick();
    chk("post_rst_done", longint'(out_valid), 0);
    chk("post_rst_sb_empty", longint'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
